// File: rtl/fetch_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_control_if
//  Description : Signal bundle between fetch_control and its pipeline peers.
//  Revision    : 1.0
// ============================================================================
interface fetch_control_if;
   logic       br_req;
   logic [9:0] br_target;
   logic       load_use_hazard;
   logic       imem_wait;
   logic       halt_req;
   logic       resume;
   logic       pc_branch;
   logic [9:0] pc_br_address;
   logic       pc_stall;
   logic       if_flush;
   logic       fetch_valid;
   logic       halted;
   logic       imem_timeout;

   // Controller side
   modport master (
      input  br_req, br_target, load_use_hazard, imem_wait, halt_req, resume,
      output pc_branch, pc_br_address, pc_stall, if_flush, fetch_valid,
             halted, imem_timeout
   );

   // Pipeline / environment side
   modport slave (
      output br_req, br_target, load_use_hazard, imem_wait, halt_req, resume,
      input  pc_branch, pc_br_address, pc_stall, if_flush, fetch_valid,
             halted, imem_timeout
   );
endinterface
`default_nettype wire

// File: rtl/fetch_control.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_control
//  Description : Instruction-fetch sequencer: branch flush, stall, halt and
//                instruction-memory wait timeout.
//  Revision    : 1.0
// ============================================================================
module fetch_control #(
   parameter int FLUSH_DEPTH = 2,
   parameter int WAIT_LIMIT  = 15
) (
   input  logic            clk,
   input  logic            reset,
   fetch_control_if.master fc
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_STALL = 3'd2,
      S_FLUSH = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);
   localparam logic [8:0] c_WAIT_LIMIT = 9'(WAIT_LIMIT);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_flush_cnt;
   logic [2:0] w_flush_cnt_nxt;
   logic [7:0] r_wait_cnt;
   logic [7:0] w_wait_cnt_nxt;
   logic       r_imem_timeout;
   logic       w_imem_timeout_nxt;

   logic       w_active;
   logic       w_pc_branch;
   logic       w_pc_stall;
   logic [8:0] w_wait_inc;
   logic       w_timeout_hit;

   assign w_active    = (r_state == S_RUN) || (r_state == S_STALL);
   assign w_pc_branch = fc.br_req && w_active;
   assign w_wait_inc  = {1'b0, r_wait_cnt} + 9'd1;
   // Timeout fires on the wait cycle whose increment reaches the limit.
   assign w_timeout_hit = (r_state == S_STALL) && fc.imem_wait &&
                          (w_wait_inc >= c_WAIT_LIMIT);

   always_comb begin
      w_pc_stall = 1'b1;
      case (r_state)
         S_IDLE:  w_pc_stall = 1'b1;
         S_RUN,
         S_STALL: w_pc_stall = (fc.load_use_hazard || fc.imem_wait) && !fc.br_req;
         S_FLUSH: w_pc_stall = fc.imem_wait;
         S_HALT:  w_pc_stall = 1'b1;
         default: w_pc_stall = 1'b1;
      endcase
   end

   assign fc.pc_branch     = w_pc_branch;
   assign fc.pc_br_address = w_pc_branch ? fc.br_target : 10'h000;
   assign fc.pc_stall      = w_pc_stall;
   assign fc.if_flush      = w_pc_branch || (r_state == S_FLUSH);
   assign fc.fetch_valid   = w_active && !w_pc_stall && !w_pc_branch;
   assign fc.halted        = (r_state == S_HALT);
   assign fc.imem_timeout  = r_imem_timeout;

   always_comb begin
      w_state_nxt        = r_state;
      w_flush_cnt_nxt    = r_flush_cnt;
      w_wait_cnt_nxt     = 8'd0;
      w_imem_timeout_nxt = r_imem_timeout;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_RUN;
         end
         S_RUN, S_STALL: begin
            if ((r_state == S_STALL) && fc.imem_wait)
               w_wait_cnt_nxt = w_wait_inc[7:0];
            if (fc.br_req) begin
               if (FLUSH_DEPTH == 1) begin
                  w_state_nxt = S_RUN;
               end else begin
                  w_state_nxt     = S_FLUSH;
                  w_flush_cnt_nxt = c_FLUSH_LOAD;
               end
            end else begin
               if (w_timeout_hit)
                  w_imem_timeout_nxt = 1'b1;
               if (fc.halt_req || w_timeout_hit)
                  w_state_nxt = S_HALT;
               else if (fc.load_use_hazard || fc.imem_wait)
                  w_state_nxt = S_STALL;
               else
                  w_state_nxt = S_RUN;
            end
         end
         S_FLUSH: begin
            // A squash slot only counts once memory actually delivers.
            if (!fc.imem_wait) begin
               if (r_flush_cnt <= 3'd1) begin
                  w_state_nxt     = S_RUN;
                  w_flush_cnt_nxt = 3'd0;
               end else begin
                  w_flush_cnt_nxt = r_flush_cnt - 3'd1;
               end
            end
         end
         S_HALT: begin
            if (fc.resume) begin
               w_state_nxt        = S_RUN;
               w_imem_timeout_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_flush_cnt    <= 3'd0;
         r_wait_cnt     <= 8'd0;
         r_imem_timeout <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_flush_cnt    <= w_flush_cnt_nxt;
         r_wait_cnt     <= w_wait_cnt_nxt;
         r_imem_timeout <= w_imem_timeout_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_control
//  Description : Scoreboard bench for fetch_control (FLUSH_DEPTH=2, WAIT_LIMIT=3).
//  Revision    : 1.0
// ============================================================================
module tb_fetch_control;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } sb_t;

   sb_t sb[$];

   fetch_control_if u_if ();

   fetch_control #(
      .FLUSH_DEPTH (2),
      .WAIT_LIMIT  (3)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .fc    (u_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_branch, pc_br_address, pc_stall, if_flush, fetch_valid, halted, imem_timeout}
   function automatic logic [15:0] ex(input logic pcb, input logic [9:0] addr,
                                      input logic st, input logic fl, input logic fv,
                                      input logic h, input logic to);
      return {pcb, addr, st, fl, fv, h, to};
   endfunction

   function automatic logic [15:0] obs();
      return {u_if.pc_branch, u_if.pc_br_address, u_if.pc_stall, u_if.if_flush,
              u_if.fetch_valid, u_if.halted, u_if.imem_timeout};
   endfunction

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic drv(input string tag, input logic br, input logic [9:0] tgt,
                      input logic lu, input logic iw, input logic hr, input logic rs,
                      input logic [15:0] want);
      sb_t e;
      @(posedge clk);
      #1;
      reset                = 1'b0;
      u_if.br_req          = br;
      u_if.br_target       = tgt;
      u_if.load_use_hazard = lu;
      u_if.imem_wait       = iw;
      u_if.halt_req        = hr;
      u_if.resume          = rs;
      e.tag = tag;
      e.val = want;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         sb_t e;
         e = sb.pop_front();
         check_eq(e.tag, obs(), e.val);
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset                = 1'b1;
      u_if.br_req          = 1'b0;
      u_if.br_target       = 10'h000;
      u_if.load_use_hazard = 1'b0;
      u_if.imem_wait       = 1'b0;
      u_if.halt_req        = 1'b0;
      u_if.resume          = 1'b0;
      #2;
      check_eq("reset_state", obs(), ex(0, 10'h000, 1, 0, 0, 0, 0));

      //   tag             br tgt      lu iw hr rs  expected
      drv("idle",          0, 10'h000, 0, 0, 0, 0, ex(0, 10'h000, 1, 0, 0, 0, 0));
      drv("run0",          0, 10'h000, 0, 0, 0, 0, ex(0, 10'h000, 0, 0, 1, 0, 0));
      drv("run1",          0, 10'h000, 0, 0, 0, 0, ex(0, 10'h000, 0, 0, 1, 0, 0));
      drv("br_run",        1, 10'h155, 0, 0, 0, 0, ex(1, 10'h155, 0, 1, 0, 0, 0));
      drv("flush",         0, 10'h000, 0, 0, 0, 0, ex(0, 10'h000, 0, 1, 0, 0, 0));
      drv("post_flush",    0, 10'h000, 0, 0, 0, 0, ex(0, 10'h000, 0, 0, 1, 0, 0));
      drv("lu_br",         1, 10'h2AA, 1, 0, 0, 0, ex(1, 10'h2AA, 0, 1, 0, 0, 0));
      drv("flush_wait",    0, 10'h000, 0, 1, 0, 0, ex(0, 10'h000, 1, 1, 0, 0, 0));
      drv("flush_br_ign",  1, 10'h3C3, 0, 0, 0, 0, ex(0, 10'h000, 0, 1, 0, 0, 0));
      drv("lu_run",        0, 10'h000, 1, 0, 0, 0, ex(0, 10'h000, 1, 0, 0, 0, 0));
      drv("lu_stall",      0, 10'h000, 1, 0, 0, 0, ex(0, 10'h000, 1, 0, 0, 0, 0));
      drv("stall_clear",   0, 10'h000, 0, 0, 0, 0, ex(0, 10'h000, 0, 0, 1, 0, 0));
      drv("iw_run",        0, 10'h000, 0, 1, 0, 0, ex(0, 10'h000, 1, 0, 0, 0, 0));
      drv("iw_s1",         0, 10'h000, 0, 1, 0, 0, ex(0, 10'h000, 1, 0, 0, 0, 0));
      drv("iw_s2",         0, 10'h000, 0, 1, 0, 0, ex(0, 10'h000, 1, 0, 0, 0, 0));
      drv("iw_s3",         0, 10'h000, 0, 1, 0, 0, ex(0, 10'h000, 1, 0, 0, 0, 0));
      drv("timeout",       1, 10'h3FF, 0, 1, 0, 0, ex(0, 10'h000, 1, 0, 0, 1, 1));
      drv("resume",        0, 10'h000, 0, 0, 0, 1, ex(0, 10'h000, 1, 0, 0, 1, 1));
      drv("after_resume",  0, 10'h000, 0, 0, 0, 0, ex(0, 10'h000, 0, 0, 1, 0, 0));
      drv("lu2",           0, 10'h000, 1, 0, 0, 0, ex(0, 10'h000, 1, 0, 0, 0, 0));
      drv("halt_stall",    0, 10'h000, 1, 0, 1, 0, ex(0, 10'h000, 1, 0, 0, 0, 0));
      drv("halt_br",       1, 10'h123, 0, 0, 0, 0, ex(0, 10'h000, 1, 0, 0, 1, 0));
      drv("halt_hold",     0, 10'h000, 0, 0, 1, 0, ex(0, 10'h000, 1, 0, 0, 1, 0));
      drv("halt_resume",   0, 10'h000, 0, 0, 0, 1, ex(0, 10'h000, 1, 0, 0, 1, 0));
      drv("run_again",     0, 10'h000, 0, 0, 0, 0, ex(0, 10'h000, 0, 0, 1, 0, 0));
      drv("iw_run2",       0, 10'h000, 0, 1, 0, 0, ex(0, 10'h000, 1, 0, 0, 0, 0));
      drv("stall_br",      1, 10'h055, 0, 1, 1, 0, ex(1, 10'h055, 0, 1, 0, 0, 0));
      drv("flush2",        0, 10'h000, 0, 0, 0, 0, ex(0, 10'h000, 0, 1, 0, 0, 0));
      drv("br3",           1, 10'h0F0, 0, 0, 0, 0, ex(1, 10'h0F0, 0, 1, 0, 0, 0));
      drv("flush_rst",     0, 10'h000, 0, 1, 0, 0, ex(0, 10'h000, 1, 1, 0, 0, 0));

      // Asynchronous reset in the middle of a waiting FLUSH cycle.
      @(negedge clk);
      #1 reset = 1'b1;
      #1 check_eq("rst_mid_flush", obs(), ex(0, 10'h000, 1, 0, 0, 0, 0));

      drv("idle_after_rst", 0, 10'h000, 0, 1, 0, 0, ex(0, 10'h000, 1, 0, 0, 0, 0));
      drv("run_after_rst",  0, 10'h000, 0, 0, 0, 0, ex(0, 10'h000, 0, 0, 1, 0, 0));

      @(negedge clk);
      #1;
      check_eq("sb_drained", 16'(sb.size()), 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
